fir_run_sequencer: RTL and testbench

//  Runs a FIR engine repeatedly on a ramp input and reports the results. Each run

---
 rtl/fir_run_sequencer_if.sv | 45 ++++
 rtl/fir_run_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fir_run_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_run_sequencer_if.sv
// Handshake bundle between the run sequencer and the FIR core: block-level
// start/idle/done plus the x (ss) and y (sm) AXI-stream channels.
interface fir_run_sequencer_if #(
    parameter int DATA_W = 32
) ();
    logic              ap_start;
    logic              ap_idle;
    logic              ap_done;
    logic              ss_tvalid;
    logic [DATA_W-1:0] ss_tdata;
    logic              ss_tlast;
    logic              ss_tready;
    logic              sm_tvalid;
    logic [DATA_W-1:0] sm_tdata;
    logic              sm_tlast;
    logic              sm_tready;

    modport master (
        output ap_start,
        input  ap_idle,
        input  ap_done,
        output ss_tvalid,
        output ss_tdata,
        output ss_tlast,
        input  ss_tready,
        input  sm_tvalid,
        input  sm_tdata,
        input  sm_tlast,
        output sm_tready
    );

    modport slave (
        input  ap_start,
        output ap_idle,
        output ap_done,
        input  ss_tvalid,
        input  ss_tdata,
        input  ss_tlast,
        output ss_tready,
        output sm_tvalid,
        output sm_tdata,
        output sm_tlast,
        input  sm_tready
    );
endinterface

// File: rtl/fir_run_sequencer.sv
// Batch sequencer that runs the FIR core on a ramp x[n]=n and reports marker bytes,
// last output byte and per-run latency. Optional watchdog: define FIR_SEQ_WDOG_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for go; outputs hold the last batch result
// S_START  | pulsing ap_start until the core drops ap_idle
// S_STREAM | feeding x beats 0..len-1, collecting y beats
// S_DRAIN  | x done; waiting for y beat len and ap_done (either order)
// S_REPORT | one cycle with 5A; next run or back to idle
module fir_run_sequencer #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 10,
    parameter int RUNS_W  = 4,
    parameter int LAT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  go,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [RUNS_W-1:0]     cfg_runs,
    fir_run_sequencer_if.master   fir,
    output logic [7:0]            checkbits,
    output logic [7:0]            final_y,
    output logic [LAT_W-1:0]      latency,
    output logic [RUNS_W-1:0]     run_idx,
    output logic                  busy,
    output logic                  err
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_DRAIN, S_REPORT} state_t;

    localparam logic [7:0] MARK_RUN  = 8'hA5;
    localparam logic [7:0] MARK_DONE = 8'h5A;
    localparam logic [7:0] MARK_WDOG = 8'hEE;

    state_t            state, state_nx;
    logic [LEN_W-1:0]  len_q, n_q, y_cnt_q;
    logic [RUNS_W-1:0] runs_q;
    logic              done_seen_q, ylast_seen_q;
    logic              active, go_ok, cfg_bad, more_runs;
    logic              x_beat, y_beat, y_is_len, y_flag_nx, done_flag_nx;
    logic [LEN_W:0]    y_num;
    logic              wdog_to;
    logic              unused_sm_bits;

    assign active  = (state == S_START) || (state == S_STREAM) || (state == S_DRAIN);
    assign go_ok   = go && !busy && (state == S_IDLE);
    assign cfg_bad = (cfg_len == '0) || (cfg_runs == '0);
    assign more_runs = ({1'b0, run_idx} + (RUNS_W+1)'(1)) < {1'b0, runs_q};

    assign fir.ap_start  = (state == S_START) && fir.ap_idle;
    assign fir.ss_tvalid = (state == S_STREAM);
    assign fir.ss_tdata  = DATA_W'(n_q);
    assign fir.ss_tlast  = (state == S_STREAM) && (n_q == len_q - LEN_W'(1));
    assign fir.sm_tready = (state == S_STREAM) || (state == S_DRAIN);

    assign x_beat   = fir.ss_tvalid && fir.ss_tready;
    assign y_beat   = fir.sm_tvalid && fir.sm_tready;
    // 1-based number of the y beat being accepted this cycle
    assign y_num    = {1'b0, y_cnt_q} + (LEN_W+1)'(1);
    assign y_is_len = (y_num == {1'b0, len_q});

    assign y_flag_nx    = ylast_seen_q || (y_beat && y_is_len);
    assign done_flag_nx = done_seen_q || fir.ap_done;

    assign unused_sm_bits = ^fir.sm_tdata[DATA_W-1:8];

`ifdef FIR_SEQ_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wdog_q;

    assign wdog_to = active && (wdog_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wdog_q <= '0;
        end else if (!active || (state_nx != state)) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + WD_W'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign wdog_to = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (go_ok && !cfg_bad) state_nx = S_START;
            S_START:  if (!fir.ap_idle) state_nx = S_STREAM;
            S_STREAM: if (x_beat && fir.ss_tlast) state_nx = S_DRAIN;
            S_DRAIN:  if (y_flag_nx && done_flag_nx) state_nx = S_REPORT;
            S_REPORT: state_nx = more_runs ? S_START : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (wdog_to) state_nx = S_IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            len_q        <= '0;
            runs_q       <= '0;
            n_q          <= '0;
            y_cnt_q      <= '0;
            done_seen_q  <= 1'b0;
            ylast_seen_q <= 1'b0;
            checkbits    <= 8'h00;
            final_y      <= 8'h00;
            latency      <= '0;
            run_idx      <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (go_ok) begin
                len_q   <= cfg_len;
                runs_q  <= cfg_runs;
                run_idx <= '0;
                err     <= cfg_bad;
                busy    <= !cfg_bad;
            end
            if (active && !done_seen_q && (latency != '1)) latency <= latency + LAT_W'(1);
            if (active && fir.ap_done) done_seen_q <= 1'b1;
            if (x_beat && !fir.ss_tlast) n_q <= n_q + LEN_W'(1);
            if (y_beat) begin
                final_y <= fir.sm_tdata[7:0];
                // beats past len are ignored for counting and framing checks
                if (!ylast_seen_q) begin
                    y_cnt_q <= y_cnt_q + LEN_W'(1);
                    if (y_is_len) ylast_seen_q <= 1'b1;
                    if (fir.sm_tlast != y_is_len) err <= 1'b1;
                end
            end
            if (state == S_REPORT) begin
                if (more_runs) run_idx <= run_idx + RUNS_W'(1);
                else           busy    <= 1'b0;
            end
            if ((state_nx == S_START) && (state != S_START)) begin
                checkbits    <= MARK_RUN;
                latency      <= '0;
                n_q          <= '0;
                y_cnt_q      <= '0;
                done_seen_q  <= 1'b0;
                ylast_seen_q <= 1'b0;
            end
            if ((state_nx == S_REPORT) && (state != S_REPORT)) checkbits <= MARK_DONE;
            if (wdog_to) begin
                err       <= 1'b1;
                checkbits <= MARK_WDOG;
                busy      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_run_sequencer.sv
// Self-checking bench: a behavioural FIR core (y = 3x) with configurable stalls and
// done/last-beat ordering drives the sequencer; a cycle-level model predicts results.
module tb_fir_run_sequencer;
`ifdef FIR_SEQ_WDOG_EN
    localparam int TB_TIMEOUT = 100;
`else
    localparam int TB_TIMEOUT = 4096;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        go;
    logic [9:0]  cfg_len;
    logic [3:0]  cfg_runs;
    logic [7:0]  checkbits, final_y;
    logic [15:0] latency;
    logic [3:0]  run_idx;
    logic        busy, err;

    fir_run_sequencer_if #(.DATA_W(32)) fi ();

    fir_run_sequencer #(
        .DATA_W(32), .LEN_W(10), .RUNS_W(4), .LAT_W(16), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .go        (go),
        .cfg_len   (cfg_len),
        .cfg_runs  (cfg_runs),
        .fir       (fi.master),
        .checkbits (checkbits),
        .final_y   (final_y),
        .latency   (latency),
        .run_idx   (run_idx),
        .busy      (busy),
        .err       (err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // FIR core model and run bookkeeping
    bit          m_run, m_stuck, m_yrand;
    int          m_len, m_tl_at, m_doff, m_rmode;
    int          x_cnt, y_sent;
    int          y_q[$];
    bit          done_sent, lasty_seen;
    int          done_cyc, lasty_cyc, start_cyc, exp_lat;
    int          report_due, run_no, reports, tlast_cnt, start_seen;
    bit          s_busy, stall_prev;
    logic [31:0] tdata_prev;
    logic        tlast_prev;

    task automatic model_reset();
        m_run = 0; m_stuck = 0; y_q.delete();
        done_sent = 0; lasty_seen = 0; report_due = -1; stall_prev = 0;
        fi.ap_idle = 1'b1; fi.ap_done = 1'b0; fi.ss_tready = 1'b1;
        fi.sm_tvalid = 1'b0; fi.sm_tdata = '0; fi.sm_tlast = 1'b0;
    endtask

    // one clock: sample at negedge, react after posedge
    task automatic tick();
        bit          x_acc, y_acc, st_acc, ok;
        logic [31:0] xd;
        logic        xl;
        @(negedge wb_clk_i);
        s_busy = busy;
        if (stall_prev && fi.ss_tvalid) begin
            n_cmp++;
            if (fi.ss_tdata !== tdata_prev || fi.ss_tlast !== tlast_prev) begin
                n_bad++;
                $display("FAIL x_stable: got data %0d last %0b, held %0d last %0b",
                         fi.ss_tdata, fi.ss_tlast, tdata_prev, tlast_prev);
            end
        end
        stall_prev = fi.ss_tvalid && !fi.ss_tready;
        tdata_prev = fi.ss_tdata;
        tlast_prev = fi.ss_tlast;
        if (cyc == report_due) begin
            n_cmp++;
            if (checkbits !== 8'h5A) begin
                n_bad++; $display("FAIL report_mark: got %h want 5a", checkbits);
            end
            n_cmp++;
            if (latency !== 16'(exp_lat)) begin
                n_bad++; $display("FAIL latency: got %0d want %0d", latency, exp_lat);
            end
            n_cmp++;
            if (run_idx !== 4'(run_no)) begin
                n_bad++; $display("FAIL run_idx: got %0d want %0d", run_idx, run_no);
            end
            run_no++; reports++; report_due = -1;
        end
        if (fi.ap_start) start_seen++;
        x_acc  = fi.ss_tvalid && fi.ss_tready;
        xd     = fi.ss_tdata;
        xl     = fi.ss_tlast;
        y_acc  = fi.sm_tvalid && fi.sm_tready;
        st_acc = fi.ap_start && !m_run && !m_stuck;
        if (st_acc) begin
            n_cmp++;
            if (checkbits !== 8'hA5) begin
                n_bad++; $display("FAIL run_mark: got %h want a5", checkbits);
            end
        end
        @(posedge wb_clk_i); #1;
        if (st_acc) begin
            m_run = 1; x_cnt = 0; y_sent = 0; y_q.delete();
            done_sent = 0; lasty_seen = 0; start_cyc = cyc;
        end
        if (x_acc && m_run) begin
            n_cmp++;
            if (xd !== 32'(x_cnt)) begin
                n_bad++; $display("FAIL x_data: got %0d want %0d", xd, x_cnt);
            end
            n_cmp++;
            if (xl !== (x_cnt == m_len - 1)) begin
                n_bad++; $display("FAIL x_last: got %0b at beat %0d of %0d", xl, x_cnt, m_len);
            end
            if (xl) tlast_cnt++;
            y_q.push_back(int'(xd) * 3);
            x_cnt++;
        end
        if (y_acc && m_run && y_q.size() > 0) begin
            void'(y_q.pop_front());
            y_sent++;
            if (y_sent == m_len) begin lasty_seen = 1; lasty_cyc = cyc; end
        end
        if (m_run && lasty_seen && done_sent) begin
            report_due = ((lasty_cyc > done_cyc) ? lasty_cyc : done_cyc) + 1;
            m_run = 0;
        end
        cyc++;
        // drive the core's outputs for the new cycle
        fi.ap_done = 1'b0;
        if (m_stuck) fi.ap_idle = 1'b1;
        else if (st_acc) fi.ap_idle = 1'b0;
        if (m_run && !done_sent) begin
            if ((m_doff > 0) ? (lasty_seen && cyc == lasty_cyc + m_doff)
                             : (x_cnt == m_len && y_sent == m_len - 1)) begin
                fi.ap_done = 1'b1; fi.ap_idle = 1'b1;
                done_sent = 1; done_cyc = cyc; exp_lat = cyc - start_cyc + 1;
            end
        end
        case (m_rmode)
            0:       fi.ss_tready = 1'b1;
            1:       fi.ss_tready = cyc[0];
            default: fi.ss_tready = 1'($urandom_range(0, 1));
        endcase
        fi.sm_tvalid = 1'b0; fi.sm_tdata = '0; fi.sm_tlast = 1'b0;
        if (m_run && y_q.size() > 0) begin
            ok = 1;
            if (y_sent == m_len - 1 && m_doff < 0) ok = done_sent && (cyc >= done_cyc - m_doff);
            if (m_yrand && $urandom_range(0, 2) == 0) ok = 0;
            if (ok) begin
                fi.sm_tvalid = 1'b1;
                fi.sm_tdata  = 32'(y_q[0]);
                fi.sm_tlast  = (y_sent + 1 == m_tl_at);
            end
        end
    endtask

    task automatic run_batch(input int len, input int runs, input int rmode, input int doff,
                             input int tl_at, input bit yrand, input int extra_go_at);
        int budget;
        bit exp_err;
        m_len = len; m_tl_at = tl_at; m_doff = doff; m_rmode = rmode; m_yrand = yrand;
        exp_err = (tl_at != len);
        run_no = 0; reports = 0; tlast_cnt = 0; report_due = -1;
        cfg_len = 10'(len); cfg_runs = 4'(runs); go = 1'b1;
        tick();
        go = 1'b0;
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL go_accept: err %0b busy %0b want err 0 busy 1", err, busy);
        end
        budget = 0;
        while ((s_busy || reports < runs) && budget < 5000) begin
            if (budget == extra_go_at) begin
                go = 1'b1; cfg_len = 10'd3; cfg_runs = 4'd1;
            end else begin
                go = 1'b0;
            end
            tick();
            budget++;
        end
        go = 1'b0;
        if (budget >= 5000) begin
            n_cmp++; n_bad++;
            $display("FAIL batch_timeout: len %0d runs %0d reports %0d", len, runs, reports);
        end
        n_cmp++;
        if (reports !== runs) begin
            n_bad++; $display("FAIL report_count: got %0d want %0d", reports, runs);
        end
        n_cmp++;
        if (tlast_cnt !== runs) begin
            n_bad++; $display("FAIL x_tlast_count: got %0d want %0d", tlast_cnt, runs);
        end
        n_cmp++;
        if (checkbits !== 8'h5A || busy !== 1'b0) begin
            n_bad++; $display("FAIL batch_end: checkbits %h busy %0b want 5a 0", checkbits, busy);
        end
        n_cmp++;
        if (run_idx !== 4'(runs - 1)) begin
            n_bad++; $display("FAIL final_run_idx: got %0d want %0d", run_idx, runs - 1);
        end
        n_cmp++;
        if (final_y !== 8'((len - 1) * 3)) begin
            n_bad++; $display("FAIL final_y: got %h want %h", final_y, 8'((len - 1) * 3));
        end
        n_cmp++;
        if (err !== exp_err) begin
            n_bad++; $display("FAIL err: got %0b want %0b", err, exp_err);
        end
        n_cmp++;
        if (latency !== 16'(exp_lat)) begin
            n_bad++; $display("FAIL latency_hold: got %0d want %0d", latency, exp_lat);
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1; go = 1'b1; cfg_len = 10'd5; cfg_runs = 4'd1;
        model_reset();
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0; go = 1'b0;
        @(negedge wb_clk_i);
        n_cmp++;
        if (checkbits !== 8'h00 || final_y !== 8'h00 || latency !== 16'h0 || run_idx !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_values: chk %h fy %h lat %0d idx %0d", checkbits, final_y, latency, run_idx);
        end
        n_cmp++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: busy %0b err %0b", busy, err);
        end
        n_cmp++;
        if (fi.ap_start !== 1'b0 || fi.ss_tvalid !== 1'b0 || fi.ss_tlast !== 1'b0 || fi.sm_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_bus: ap_start %0b ss_tvalid %0b ss_tlast %0b sm_tready %0b",
                     fi.ap_start, fi.ss_tvalid, fi.ss_tlast, fi.sm_tready);
        end
        @(posedge wb_clk_i); #1;
        start_seen = 0;
        repeat (3) tick();
        n_cmp++;
        if (s_busy !== 1'b0 || start_seen !== 0) begin
            n_bad++; $display("FAIL go_in_reset: busy %0b ap_start cycles %0d want 0 0", s_busy, start_seen);
        end
    endtask

    task automatic test_zero_cfg();
        start_seen = 0;
        go = 1'b1; cfg_len = 10'd0; cfg_runs = 4'd2;
        tick();
        go = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL zero_len: err %0b busy %0b want 1 0", err, busy);
        end
        go = 1'b1; cfg_len = 10'd4; cfg_runs = 4'd0;
        tick();
        go = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || start_seen !== 0) begin
            n_bad++;
            $display("FAIL zero_runs: err %0b busy %0b ap_start cycles %0d want 1 0 0", err, busy, start_seen);
        end
    endtask

    task automatic test_reset_midrun();
        m_len = 32; m_tl_at = 32; m_doff = 2; m_rmode = 0; m_yrand = 0;
        go = 1'b1; cfg_len = 10'd32; cfg_runs = 4'd2;
        tick();
        go = 1'b0;
        repeat (12) tick();
        wb_rst_i = 1'b1;
        tick();
        n_cmp++;
        if (checkbits !== 8'h00 || busy !== 1'b0 || latency !== 16'h0 || final_y !== 8'h00) begin
            n_bad++;
            $display("FAIL midrun_reset: chk %h busy %0b lat %0d fy %h", checkbits, busy, latency, final_y);
        end
        n_cmp++;
        if (fi.ss_tvalid !== 1'b0 || fi.sm_tready !== 1'b0 || fi.ap_start !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_bus: ss_tvalid %0b sm_tready %0b ap_start %0b",
                     fi.ss_tvalid, fi.sm_tready, fi.ap_start);
        end
        wb_rst_i = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_random();
        int len, runs, d;
        for (int i = 0; i < 6; i++) begin
            len  = $urandom_range(1, 40);
            runs = $urandom_range(1, 4);
            d    = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) d = -d;
            run_batch(len, runs, 2, d, len, 1'b1, -1);
        end
    endtask

`ifdef FIR_SEQ_WDOG_EN
    task automatic test_watchdog();
        m_stuck = 1; m_len = 8; m_tl_at = 8; m_doff = 1; m_rmode = 0; m_yrand = 0;
        go = 1'b1; cfg_len = 10'd8; cfg_runs = 4'd1;
        tick();
        go = 1'b0;
        repeat (99) tick();
        n_cmp++;
        if (checkbits !== 8'hA5 || busy !== 1'b1) begin
            n_bad++; $display("FAIL wdog_early: chk %h busy %0b want a5 1", checkbits, busy);
        end
        tick();
        n_cmp++;
        if (checkbits !== 8'hEE || err !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL wdog_fire: chk %h err %0b busy %0b want ee 1 0", checkbits, err, busy);
        end
        model_reset();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        run_batch(64, 3, 0, 1, 64, 1'b0, -1);   // main: 3 runs, ready core
        run_batch(8, 1, 1, 1, 8, 1'b0, -1);     // toggling ss_tready
        run_batch(16, 1, 0, -5, 16, 1'b0, -1);  // ap_done 5 cycles before last y
        run_batch(16, 1, 0, 5, 16, 1'b0, -1);   // ap_done 5 cycles after last y
        run_batch(16, 1, 0, 2, 10, 1'b0, -1);   // early sm_tlast on beat 10
        run_batch(16, 1, 2, 3, 16, 1'b0, -1);   // next go clears err
        test_zero_cfg();
        run_batch(1, 1, 0, -1, 1, 1'b0, -1);    // back to back, shortest run
        run_batch(2, 15, 0, 1, 2, 1'b0, 5);     // max runs, go while busy dropped
        test_random();
        test_reset_midrun();
        run_batch(5, 2, 1, 2, 5, 1'b1, -1);     // recovers after mid-run reset
`ifdef FIR_SEQ_WDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
